// File: rtl/adc_multichannel_combiner.sv
// Multichannel ramp-ADC code combiner: pairs rise/fall fine TDC values per channel,
// forms a saturated OFFSET + rise - fall code, optionally averages it, and streams it out round-robin.
module adc_multichannel_combiner #(
  parameter int CHANNELS  = 4,
  parameter int FINE_BITS = 9,
  parameter int OFFSET    = 255,
  parameter int AVG_LOG2  = 0
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            enable,
  input  logic                                            clear_status,
  input  logic [CHANNELS-1:0]                             rise_valid,
  input  logic [CHANNELS*FINE_BITS-1:0]                   rise_value,
  input  logic [CHANNELS-1:0]                             fall_valid,
  input  logic [CHANNELS*FINE_BITS-1:0]                   fall_value,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [FINE_BITS:0]                              out_data,
  output logic [$clog2((CHANNELS < 2) ? 2 : CHANNELS)-1:0] out_channel,
  output logic [CHANNELS-1:0]                             err_orphan,
  output logic [CHANNELS-1:0]                             overflow
);

  localparam int OUT_BITS = FINE_BITS + 1;
  localparam int CH_BITS  = $clog2((CHANNELS < 2) ? 2 : CHANNELS);
  localparam int ACC_BITS = OUT_BITS + AVG_LOG2;
  localparam int CNT_BITS = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_BITS = FINE_BITS + 3;
  localparam int CODE_MAX = (1 << OUT_BITS) - 1;
  localparam int unsigned NCH = CHANNELS;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'((1 << AVG_LOG2) - 1);

  typedef enum logic {WAIT_RISE = 1'b0, WAIT_FALL = 1'b1} state_t;

  // Signed range of OFFSET + rise - fall always fits in SUM_BITS, so the MSB is the sign.
  function automatic logic [OUT_BITS-1:0] clamp_code(input logic [FINE_BITS-1:0] rise,
                                                     input logic [FINE_BITS-1:0] fall);
    logic [SUM_BITS-1:0] s;
    s = SUM_BITS'(OFFSET) + {3'b000, rise} - {3'b000, fall};
    if (s[SUM_BITS-1]) return '0;
    else if (s > SUM_BITS'(CODE_MAX)) return '1;
    else return s[OUT_BITS-1:0];
  endfunction

  function automatic logic [CH_BITS-1:0] wrap_idx(input logic [CH_BITS-1:0] base,
                                                  input int unsigned off);
    int unsigned s;
    s = off + {{(32-CH_BITS){1'b0}}, base};
    if (s >= NCH) s = s - NCH;
    return s[CH_BITS-1:0];
  endfunction

  logic                         r_out_valid;
  logic [OUT_BITS-1:0]          r_out_data;
  logic [CH_BITS-1:0]           r_out_channel;
  logic [CH_BITS-1:0]           r_ptr;
  logic                         w_out_free;
  logic                         w_gnt_vld;
  logic [CH_BITS-1:0]           w_gnt_idx;
  logic [CH_BITS-1:0]           w_cand;
  logic [CHANNELS-1:0]          w_pend_v;
  logic [CHANNELS*OUT_BITS-1:0] w_hold_flat;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    state_t               r_state, w_state_nxt;
    logic [FINE_BITS-1:0] r_rise, w_rise_nxt, w_rise_in, w_fall_in, w_pair_rise;
    logic                 w_pair, w_orphan;
    logic                 r_p_vld;
    logic [FINE_BITS-1:0] r_p_rise, r_p_fall;
    logic                 r_s1_vld;
    logic [OUT_BITS-1:0]  r_s1_smp;
    logic [ACC_BITS-1:0]  r_acc, w_sum;
    logic [CNT_BITS-1:0]  r_cnt;
    logic                 w_res_vld;
    logic [OUT_BITS-1:0]  w_res;
    logic                 r_pend, w_gnt_me, w_drop, r_err, r_ovf;
    logic [OUT_BITS-1:0]  r_hold;

    assign w_rise_in = rise_value[k*FINE_BITS +: FINE_BITS];
    assign w_fall_in = fall_value[k*FINE_BITS +: FINE_BITS];

    // Edge pairing FSM: decides pairing, rise latching and orphan events
    always_comb begin
      w_state_nxt = r_state;
      w_rise_nxt  = r_rise;
      w_pair      = 1'b0;
      w_pair_rise = r_rise;
      w_orphan    = 1'b0;
      if (!enable) begin
        w_state_nxt = WAIT_RISE;
      end else begin
        case (r_state)
          WAIT_RISE: begin
            if (rise_valid[k] && fall_valid[k]) begin
              w_pair      = 1'b1;
              w_pair_rise = w_rise_in;
            end else if (rise_valid[k]) begin
              w_rise_nxt  = w_rise_in;
              w_state_nxt = WAIT_FALL;
            end else if (fall_valid[k]) begin
              w_orphan = 1'b1;
            end else begin
              w_state_nxt = WAIT_RISE;
            end
          end
          WAIT_FALL: begin
            if (fall_valid[k]) begin
              w_pair = 1'b1;
              if (rise_valid[k]) w_rise_nxt = w_rise_in;
              else w_state_nxt = WAIT_RISE;
            end else if (rise_valid[k]) begin
              w_rise_nxt = w_rise_in;
              w_orphan   = 1'b1;
            end else begin
              w_state_nxt = WAIT_FALL;
            end
          end
          default: w_state_nxt = WAIT_RISE;
        endcase
      end
    end

    // FSM state and the raw pair captured on the pairing edge
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_state  <= WAIT_RISE;
        r_rise   <= '0;
        r_p_vld  <= 1'b0;
        r_p_rise <= '0;
        r_p_fall <= '0;
      end else begin
        r_state  <= w_state_nxt;
        r_rise   <= w_rise_nxt;
        r_p_vld  <= w_pair;
        r_p_rise <= w_pair_rise;
        r_p_fall <= w_fall_in;
      end
    end

    // S1: saturated sample
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_s1_vld <= 1'b0;
        r_s1_smp <= '0;
      end else begin
        r_s1_vld <= r_p_vld;
        r_s1_smp <= clamp_code(r_p_rise, r_p_fall);
      end
    end

    assign w_sum     = r_acc + ACC_BITS'(r_s1_smp);
    assign w_res_vld = enable && r_s1_vld && (r_cnt == CNT_LAST);
    assign w_res     = OUT_BITS'(w_sum >> AVG_LOG2);

    // Averaging accumulator; the last sample of a block is added combinationally into the result
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (!enable || w_res_vld) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_s1_vld) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_BITS'(1);
      end
    end

    assign w_gnt_me = w_gnt_vld && (w_gnt_idx == CH_BITS'(k));
    assign w_drop   = w_res_vld && r_pend && !w_gnt_me;

    // Holding register: a result landing on a granted entry replaces it, otherwise it is dropped
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_pend <= 1'b0;
        r_hold <= '0;
      end else if (w_res_vld && !w_drop) begin
        r_pend <= 1'b1;
        r_hold <= w_res;
      end else if (w_gnt_me) begin
        r_pend <= 1'b0;
      end
    end

    // Sticky status; a same-cycle event takes priority over clear_status
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_err <= 1'b0;
        r_ovf <= 1'b0;
      end else begin
        if (w_orphan) r_err <= 1'b1;
        else if (clear_status) r_err <= 1'b0;
        if (w_drop) r_ovf <= 1'b1;
        else if (clear_status) r_ovf <= 1'b0;
      end
    end

    assign w_pend_v[k]                           = r_pend;
    assign w_hold_flat[k*OUT_BITS +: OUT_BITS]   = r_hold;
    assign err_orphan[k]                         = r_err;
    assign overflow[k]                           = r_ovf;
  end

  assign w_out_free = !r_out_valid || out_ready;

  // Round-robin grant: first pending channel at or after the pointer
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cand = wrap_idx(r_ptr, i);
      if (w_out_free && !w_gnt_vld && w_pend_v[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end else begin
        w_gnt_vld = w_gnt_vld;
      end
    end
  end

  // Output register; data and channel hold while stalled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_channel <= '0;
      r_ptr         <= '0;
    end else if (w_gnt_vld) begin
      r_out_valid   <= 1'b1;
      r_out_data    <= w_hold_flat[w_gnt_idx*OUT_BITS +: OUT_BITS];
      r_out_channel <= w_gnt_idx;
      r_ptr         <= wrap_idx(w_gnt_idx, 1);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_channel = r_out_channel;

endmodule

// File: tb/tb_adc_multichannel_combiner.sv
// Self-checking bench: directed scenarios on three parameterisations plus a randomized
// run checked against a per-channel pairing model.
module tb_adc_multichannel_combiner;
  localparam int CH = 4;
  localparam int FB = 9;

  logic clock = 1'b0, reset = 1'b0, enable = 1'b0, clear_status = 1'b0, out_ready = 1'b0;
  logic [CH-1:0]    rise_valid = '0, fall_valid = '0;
  logic [CH*FB-1:0] rise_value = '0, fall_value = '0;

  logic d_ov, s_ov, a_ov;
  logic [9:0] d_od, s_od, a_od;
  logic [1:0] d_oc, s_oc, a_oc;
  logic [3:0] d_err, s_err, a_err, d_ovf, s_ovf, a_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] q_d[$], q_s[$], q_a[$];

  adc_multichannel_combiner #(.CHANNELS(4), .FINE_BITS(9), .OFFSET(255), .AVG_LOG2(0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear_status(clear_status),
    .rise_valid(rise_valid), .rise_value(rise_value), .fall_valid(fall_valid), .fall_value(fall_value),
    .out_valid(d_ov), .out_ready(out_ready), .out_data(d_od), .out_channel(d_oc),
    .err_orphan(d_err), .overflow(d_ovf));

  adc_multichannel_combiner #(.CHANNELS(4), .FINE_BITS(9), .OFFSET(1000), .AVG_LOG2(0)) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .clear_status(clear_status),
    .rise_valid(rise_valid), .rise_value(rise_value), .fall_valid(fall_valid), .fall_value(fall_value),
    .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od), .out_channel(s_oc),
    .err_orphan(s_err), .overflow(s_ovf));

  adc_multichannel_combiner #(.CHANNELS(4), .FINE_BITS(9), .OFFSET(255), .AVG_LOG2(2)) dut_avg (
    .clock(clock), .reset(reset), .enable(enable), .clear_status(clear_status),
    .rise_valid(rise_valid), .rise_value(rise_value), .fall_valid(fall_valid), .fall_value(fall_value),
    .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .out_channel(a_oc),
    .err_orphan(a_err), .overflow(a_ovf));

  always #5 clock = ~clock;

  // Inputs change 1ns after posedge, so a negedge sample sees the handshake of the next edge.
  always @(negedge clock) begin
    if (d_ov && out_ready) q_d.push_back({d_oc, d_od});
    if (s_ov && out_ready) q_s.push_back({s_oc, s_od});
    if (a_ov && out_ready) q_a.push_back({a_oc, a_od});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int ref_code(input int off, input int r, input int f);
    int s;
    s = off + r - f;
    if (s < 0) return 0;
    if (s > 1023) return 1023;
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clr_strobes();
    rise_valid   = '0;
    fall_valid   = '0;
    clear_status = 1'b0;
  endtask

  task automatic strobe(input int ch, input bit rv, input int r, input bit fv, input int f);
    rise_valid[ch]             = rv;
    rise_value[ch*FB +: FB]    = FB'(r);
    fall_valid[ch]             = fv;
    fall_value[ch*FB +: FB]    = FB'(f);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    clr_strobes();
    out_ready = 1'b1;
    tick(2);
    q_d.delete(); q_s.delete(); q_a.delete();
    reset = 1'b1;
    enable = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (d_ov !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d expected 0", d_ov); end
    n_tests++; if (d_od !== 10'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", d_od); end
    n_tests++; if (d_oc !== 2'd0) begin n_fail++; $display("FAIL reset_channel: got %0d expected 0", d_oc); end
    n_tests++; if ({d_err, d_ovf} !== 8'd0) begin n_fail++; $display("FAIL reset_status: got %h expected 00", {d_err, d_ovf}); end
  endtask

  task automatic test_latency();
    int lat;
    logic [9:0] od;
    logic [1:0] oc;
    do_reset();
    lat = -1; od = '0; oc = '0;
    strobe(0, 1, 100, 0, 0); tick(1); clr_strobes(); tick(1);
    strobe(0, 0, 0, 1, 40);  tick(1); clr_strobes();
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (lat < 0 && d_ov) begin lat = i; od = d_od; oc = d_oc; end
    end
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL latency: got %0d expected 3", lat); end
    n_tests++; if (od !== 10'(ref_code(255, 100, 40))) begin n_fail++; $display("FAIL latency_data: got %0d expected 315", od); end
    n_tests++; if (oc !== 2'd0) begin n_fail++; $display("FAIL latency_channel: got %0d expected 0", oc); end
  endtask

  task automatic test_saturation();
    do_reset();
    strobe(0, 1, 0, 1, 400); tick(1); clr_strobes(); tick(6);
    strobe(0, 1, 511, 1, 0); tick(1); clr_strobes(); tick(6);
    n_tests++; if (q_d.size() != 2) begin n_fail++; $display("FAIL sat_count: got %0d expected 2", q_d.size()); end
    else begin
      n_tests++; if (q_d[0] !== {2'd0, 10'(ref_code(255, 0, 400))}) begin n_fail++; $display("FAIL sat_low: got %0d expected 0", q_d[0][9:0]); end
      n_tests++; if (q_d[1] !== {2'd0, 10'(ref_code(255, 511, 0))}) begin n_fail++; $display("FAIL sat_mid: got %0d expected 766", q_d[1][9:0]); end
    end
    n_tests++; if (q_s.size() != 2) begin n_fail++; $display("FAIL sat_hi_count: got %0d expected 2", q_s.size()); end
    else begin
      n_tests++; if (q_s[0] !== {2'd0, 10'(ref_code(1000, 0, 400))}) begin n_fail++; $display("FAIL sat_hi_mid: got %0d expected 600", q_s[0][9:0]); end
      n_tests++; if (q_s[1] !== {2'd0, 10'(ref_code(1000, 511, 0))}) begin n_fail++; $display("FAIL sat_high: got %0d expected 1023", q_s[1][9:0]); end
    end
  endtask

  task automatic test_average();
    int d[4] = '{45, 46, 47, 50};
    int sum, r, f;
    do_reset();
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      f = $urandom_range(0, 400);
      r = f + d[i];
      sum += ref_code(255, r, f);
      strobe(2, 1, r, 1, f); tick(1); clr_strobes(); tick(1);
      if (i == 2) begin
        tick(8);
        n_tests++; if (q_a.size() != 0) begin n_fail++; $display("FAIL avg_early: got %0d outputs expected 0", q_a.size()); end
      end
    end
    tick(8);
    n_tests++; if (q_a.size() != 1) begin n_fail++; $display("FAIL avg_count: got %0d expected 1", q_a.size()); end
    else begin
      n_tests++; if (q_a[0] !== {2'd2, 10'(sum >> 2)}) begin n_fail++; $display("FAIL avg_value: got ch%0d/%0d expected ch2/%0d", q_a[0][11:10], q_a[0][9:0], sum >> 2); end
    end
  endtask

  task automatic test_stall_order();
    int e[4];
    int r, f;
    do_reset();
    out_ready = 1'b0;
    for (int c = 1; c < 4; c++) begin
      r = $urandom_range(0, 511); f = $urandom_range(0, 511);
      e[c] = ref_code(255, r, f);
      strobe(c, 1, r, 1, f);
    end
    tick(1); clr_strobes(); tick(3);
    n_tests++; if ({d_ov, d_oc, d_od} !== {1'b1, 2'd1, 10'(e[1])}) begin n_fail++; $display("FAIL stall_first: got v%0d ch%0d %0d expected v1 ch1 %0d", d_ov, d_oc, d_od, e[1]); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_tests++; if ({d_ov, d_oc, d_od} !== {1'b1, 2'd1, 10'(e[1])}) begin n_fail++; $display("FAIL stall_hold: got v%0d ch%0d %0d expected v1 ch1 %0d", d_ov, d_oc, d_od, e[1]); end
    end
    out_ready = 1'b1;
    tick(6);
    n_tests++; if (q_d.size() != 3) begin n_fail++; $display("FAIL stall_count: got %0d expected 3", q_d.size()); end
    else begin
      for (int c = 1; c < 4; c++) begin
        n_tests++; if (q_d[c-1] !== {2'(c), 10'(e[c])}) begin n_fail++; $display("FAIL stall_order: got ch%0d/%0d expected ch%0d/%0d", q_d[c-1][11:10], q_d[c-1][9:0], c, e[c]); end
      end
    end
    n_tests++; if (d_ovf !== 4'd0) begin n_fail++; $display("FAIL stall_overflow: got %b expected 0000", d_ovf); end
  endtask

  task automatic test_orphan();
    do_reset();
    strobe(0, 0, 0, 1, $urandom_range(0, 511)); tick(1); clr_strobes(); tick(5);
    n_tests++; if (d_err !== 4'b0001) begin n_fail++; $display("FAIL orphan_fall: got %b expected 0001", d_err); end
    n_tests++; if (q_d.size() != 0) begin n_fail++; $display("FAIL orphan_no_out: got %0d expected 0", q_d.size()); end
    strobe(0, 1, 10, 0, 0); tick(1); clr_strobes();
    strobe(0, 1, 20, 0, 0); tick(1); clr_strobes();
    strobe(0, 0, 0, 1, 5);  tick(1); clr_strobes(); tick(6);
    n_tests++; if (q_d.size() != 1) begin n_fail++; $display("FAIL orphan_count: got %0d expected 1", q_d.size()); end
    else begin
      n_tests++; if (q_d[0] !== {2'd0, 10'd270}) begin n_fail++; $display("FAIL orphan_data: got %0d expected 270", q_d[0][9:0]); end
    end
    n_tests++; if (d_err !== 4'b0001) begin n_fail++; $display("FAIL orphan_sticky: got %b expected 0001", d_err); end
    clear_status = 1'b1;
    strobe(3, 0, 0, 1, 7); tick(1); clr_strobes(); tick(1);
    n_tests++; if (d_err !== 4'b1000) begin n_fail++; $display("FAIL orphan_clear_vs_event: got %b expected 1000", d_err); end
    clear_status = 1'b1; tick(1); clr_strobes(); tick(1);
    n_tests++; if (d_err !== 4'b0000) begin n_fail++; $display("FAIL orphan_clear: got %b expected 0000", d_err); end
  endtask

  task automatic test_enable();
    do_reset();
    strobe(0, 1, 77, 0, 0); tick(1); clr_strobes();
    enable = 1'b0;
    strobe(1, 0, 0, 1, 33); tick(1); clr_strobes();
    enable = 1'b1;
    strobe(0, 0, 0, 1, 12); tick(1); clr_strobes(); tick(6);
    n_tests++; if (d_err !== 4'b0001) begin n_fail++; $display("FAIL enable_status: got %b expected 0001", d_err); end
    n_tests++; if (q_d.size() != 0) begin n_fail++; $display("FAIL enable_no_out: got %0d expected 0", q_d.size()); end
  endtask

  task automatic test_overflow();
    int e[3];
    int r, f;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(0, 511); f = $urandom_range(0, 511);
      e[i] = ref_code(255, r, f);
      strobe(0, 1, r, 1, f); tick(1);
    end
    clr_strobes(); tick(6);
    n_tests++; if (d_ovf !== 4'b0001) begin n_fail++; $display("FAIL ovf_flag: got %b expected 0001", d_ovf); end
    n_tests++; if ({d_ov, d_od} !== {1'b1, 10'(e[0])}) begin n_fail++; $display("FAIL ovf_head: got v%0d %0d expected v1 %0d", d_ov, d_od, e[0]); end
    out_ready = 1'b1; tick(6);
    n_tests++; if (q_d.size() != 2) begin n_fail++; $display("FAIL ovf_kept: got %0d expected 2", q_d.size()); end
    else begin
      n_tests++; if (q_d[0] !== {2'd0, 10'(e[0])}) begin n_fail++; $display("FAIL ovf_first: got %0d expected %0d", q_d[0][9:0], e[0]); end
      n_tests++; if (q_d[1] !== {2'd0, 10'(e[1])}) begin n_fail++; $display("FAIL ovf_second: got %0d expected %0d", q_d[1][9:0], e[1]); end
    end
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe(0, 1, $urandom_range(0, 511), 1, $urandom_range(0, 511)); tick(1);
    end
    clr_strobes(); tick(6);
    #2; reset = 1'b0; #1;
    q_d.delete();
    n_tests++; if ({d_ov, d_od, d_err, d_ovf} !== 19'd0) begin n_fail++; $display("FAIL midreset_state: got %h expected 0", {d_ov, d_od, d_err, d_ovf}); end
    tick(1);
    reset = 1'b1; out_ready = 1'b1;
    tick(10);
    n_tests++; if (q_d.size() != 0) begin n_fail++; $display("FAIL midreset_no_out: got %0d expected 0", q_d.size()); end
  endtask

  task automatic test_random();
    bit has_r[4];
    int st_r[4];
    logic [3:0] exp_err;
    logic [11:0] exp_q[$], e_c[$], a_c[$];
    do_reset();
    exp_err = '0;
    for (int c = 0; c < 4; c++) begin has_r[c] = 1'b0; st_r[c] = 0; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      clr_strobes();
      if ($urandom_range(0, 1) == 1) begin
        int ch, kind, r, f;
        bit rv, fv;
        ch = $urandom_range(0, 3); kind = $urandom_range(1, 3);
        r = $urandom_range(0, 511); f = $urandom_range(0, 511);
        rv = kind[0]; fv = kind[1];
        strobe(ch, rv, r, fv, f);
        if (!has_r[ch]) begin
          if (rv && fv) exp_q.push_back({2'(ch), 10'(ref_code(255, r, f))});
          else if (rv) begin has_r[ch] = 1'b1; st_r[ch] = r; end
          else exp_err[ch] = 1'b1;
        end else begin
          if (fv) begin
            exp_q.push_back({2'(ch), 10'(ref_code(255, st_r[ch], f))});
            if (rv) st_r[ch] = r;
            else has_r[ch] = 1'b0;
          end else begin
            st_r[ch] = r;
            exp_err[ch] = 1'b1;
          end
        end
      end
      tick(1);
    end
    clr_strobes(); tick(10);
    for (int c = 0; c < 4; c++) begin
      e_c.delete(); a_c.delete();
      foreach (exp_q[i]) if (exp_q[i][11:10] == 2'(c)) e_c.push_back(exp_q[i]);
      foreach (q_d[i]) if (q_d[i][11:10] == 2'(c)) a_c.push_back(q_d[i]);
      n_tests++; if (a_c.size() != e_c.size()) begin n_fail++; $display("FAIL rand_count_ch%0d: got %0d expected %0d", c, a_c.size(), e_c.size()); end
      for (int i = 0; i < e_c.size() && i < a_c.size(); i++) begin
        n_tests++; if (a_c[i] !== e_c[i]) begin n_fail++; $display("FAIL rand_data_ch%0d[%0d]: got %0d expected %0d", c, i, a_c[i][9:0], e_c[i][9:0]); end
      end
    end
    n_tests++; if (d_err !== exp_err) begin n_fail++; $display("FAIL rand_orphan: got %b expected %b", d_err, exp_err); end
    n_tests++; if (d_ovf !== 4'd0) begin n_fail++; $display("FAIL rand_overflow: got %b expected 0000", d_ovf); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_saturation();
    test_average();
    test_stall_order();
    test_orphan();
    test_enable();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
